inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
On-chip instruction generator that drives the fullchip instruction bus (19-bit inst) and the mem_in data bus autonomously.
- Replaces hand-scripted host stimulus with a hardware initiator.
- Accepts Q rows then K rows from a host valid/ready stream.
- Then issues the fixed run: Q write, K write, K load, execute, ofifo-to-pmem drain.
- Sits between the host interface and the fullchip top.

Parameters:
bw, 8, element bit width
pr, 8, elements per mem_in word (mem_in width pr*bw)
col, 8, number of K vectors / dot-product columns (≤16)
total_cycle, 8, number of Q vectors (≤16)
idle_gap, 10, idle cycles after load phase; idle_gap+1 after execute phase

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle run request; ignored while busy
in_valid  in  1  host data word valid
in_ready  out  1  sequencer accepts a word this cycle
in_data  in  pr*bw  host Q/K row, lane j at [(j+1)*bw-1:j*bw]
mem_in  out  pr*bw  registered data to fullchip
inst  out  19  registered instruction word to fullchip
busy  out  1  high from the edge that samples start until done
done  out  1  one-cycle pulse at run end

Behaviour:
- inst fields:
  - [18] div = 0 and [17] acc = 0, always.
  - [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add.
  - [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd = 0 always, [0] pmem_wr.
- inst, mem_in, busy and done are registered. in_ready is combinational from the state: 1 only in QWR/KWR.
- Reset (async, any time, including mid-run): state IDLE, all counters 0, inst=0, mem_in=0, busy=0, done=0.
- In every cycle not listed below, inst=0. mem_in holds its last value.
- States and transitions:
  - IDLE: start=1 → QWR, busy←1.
  - QWR: each accepted word (in_valid&in_ready) sets next-cycle inst qmem_wr=1, qkmem_add=word index (0..total_cycle-1), mem_in=in_data. Each non-accept cycle emits inst=0 (bubble, index unchanged). After total_cycle accepts → GAP_Q.
  - GAP_Q: 1 cycle → KWR.
  - KWR: same as QWR but sets kmem_wr, indices 0..col-1. After col accepts → GAP_K.
  - GAP_K: 3 cycles → LOAD.
  - LOAD: col+2 cycles, load=1 throughout. Cycle 0 has load only. Cycles 1..col add kmem_rd=1 with qkmem_add=0..col-1. Cycle col+1 has load only. → GAP_L.
  - GAP_L: idle_gap cycles → EXEC.
  - EXEC: total_cycle cycles with execute=1, qmem_rd=1, qkmem_add=0..total_cycle-1. → GAP_E.
  - GAP_E: idle_gap+1 cycles → DRAIN.
  - DRAIN: total_cycle cycles with ofifo_rd=1, pmem_wr=1, pmem_add=0..total_cycle-1. → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Latency with no bubbles, edge 0 samples start:
  - qmem_wr after edges 1–8; kmem_wr after edges 10–17.
  - load after edges 21–30, with kmem_rd after edges 22–29.
  - execute after edges 41–48; drain after edges 60–67; done after edge 68.
- Boundaries:
  - start while busy is ignored.
  - in_valid outside QWR/KWR is ignored and not consumed.
  - Address counters never wrap; parameter range is enforced ≤16.
  - Back-to-back start in the DONE cycle is ignored; start is accepted from IDLE only.

Decomposition:
- Package fullchip_pkg:
  - inst bit-position constants: INST_W=19, OFIFO_RD=16, QKADD_HI/LO=15/12, PADD_HI/LO=11/8, EXEC=7, LOAD=6, QRD=5, QWR=4, KRD=3, KWR=2, PRD=1, PWR=0.
  - state enum.
- One sub-module, phase_counter: a loadable down-counter with terminal flag, reused by the gap and phase states.
- The address index is a separate up-counter in the top.

Test Plan:
1. Reset, start, in_valid held high with Q rows 0x01..0x08 then K rows 0x11..0x18 → exact edge schedule above. qkmem_add increments 0..7 in each phase. mem_in equals each accepted row one cycle after accept. done after edge 68.
2. Bubbles: deassert in_valid for 2 cycles after the 3rd Q word → inst=0 for those 2 cycles, next qmem_wr carries add=3, all later phases shift by 2, done after edge 70.
3. start pulsed during EXEC → no effect; single done pulse; inst[18:17] stay 0 throughout.
4. Async reset asserted mid-LOAD, between clock edges → inst=0, busy=0 immediately. A fresh start then reruns from QWR with add=0.
5. Parameters col=4, total_cycle=16, idle_gap=2 → 16 Q accepts (add 0..15, no wrap), LOAD 6 cycles, GAP_E 3 cycles, DRAIN pmem_add 0..15.
6. Host asserts in_valid in IDLE and GAP_Q → in_ready=0 and no memory write. The word is consumed only once KWR is entered.

Source files
------------

// File: rtl/fullchip_pkg.sv
// Shared definitions for the fullchip instruction sequencer: the bit layout
// of the 19-bit instruction word and the sequencer state encoding.
package fullchip_pkg;

  localparam int INST_W   = 19;
  localparam int DIV      = 18;
  localparam int ACC      = 17;
  localparam int OFIFO_RD = 16;
  localparam int QKADD_HI = 15;
  localparam int QKADD_LO = 12;
  localparam int PADD_HI  = 11;
  localparam int PADD_LO  = 8;
  localparam int EXEC     = 7;
  localparam int LOAD     = 6;
  localparam int QRD      = 5;
  localparam int QWR      = 4;
  localparam int KRD      = 3;
  localparam int KWR      = 2;
  localparam int PRD      = 1;
  localparam int PWR      = 0;

  // Phase counter width covers idle_gap up to 255 and col+1 up to 17.
  localparam int CNT_W  = 8;
  // Address index width; sizes are capped at 16 so 4 bits never wrap.
  localparam int ADDR_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_GAP_Q,
    S_KWR,
    S_GAP_K,
    S_LOAD,
    S_GAP_L,
    S_EXEC,
    S_GAP_E,
    S_DRAIN,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with terminal flag. Sequences the fixed-length
// gap states and the load phase. Load takes priority over decrement and the
// count saturates at zero.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Remaining-cycle count: reload on phase entry, else count down to zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                    cnt_q <= '0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/inst_sequencer.sv
// Autonomous instruction generator for the fullchip top. Collects Q then K
// rows from a host valid/ready stream, then replays the fixed run:
// K load, execute, and ofifo-to-pmem drain, with fixed idle gaps between.
module inst_sequencer
  import fullchip_pkg::*;
#(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int idle_gap    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [pr*bw-1:0]   in_data,
  output logic [pr*bw-1:0]   mem_in,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done
);

  // Address fields are 4 bits wide, so sizes beyond 16 would wrap silently.
  if (col < 1 || col > 16) begin : g_bad_col
    $error("inst_sequencer: col must be in 1..16");
  end
  if (total_cycle < 1 || total_cycle > 16) begin : g_bad_tc
    $error("inst_sequencer: total_cycle must be in 1..16");
  end
  if (idle_gap < 1 || idle_gap > 254) begin : g_bad_gap
    $error("inst_sequencer: idle_gap must be in 1..254");
  end

  // Counter reload values are "cycles in phase minus one".
  localparam logic [CNT_W-1:0]  LD_GAPQ = '0;
  localparam logic [CNT_W-1:0]  LD_GAPK = CNT_W'(2);
  localparam logic [CNT_W-1:0]  LD_LOAD = CNT_W'(col + 1);
  localparam logic [CNT_W-1:0]  LD_GAPL = CNT_W'(idle_gap - 1);
  localparam logic [CNT_W-1:0]  LD_GAPE = CNT_W'(idle_gap);
  localparam logic [ADDR_W-1:0] Q_LAST  = ADDR_W'(total_cycle - 1);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(col - 1);

  seq_state_e           state_q;
  logic [ADDR_W-1:0]    idx_q;
  logic [INST_W-1:0]    inst_q;
  logic [pr*bw-1:0]     mem_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 pc_load_d;
  logic [CNT_W-1:0]     pc_val_d;
  logic                 pc_dec_d;
  logic [CNT_W-1:0]     pc_cnt;
  logic                 pc_tc;
  logic                 accept;

  assign in_ready = (state_q == S_QWR) || (state_q == S_KWR);
  assign accept   = in_valid && in_ready;

  phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (pc_load_d),
    .load_val_i (pc_val_d),
    .dec_i      (pc_dec_d),
    .cnt_o      (pc_cnt),
    .tc_o       (pc_tc)
  );

  // Phase counter control: load the next timed phase on the leaving edge,
  // count down while inside a timed phase.
  always_comb begin
    pc_load_d = 1'b0;
    pc_val_d  = '0;
    pc_dec_d  = 1'b0;
    case (state_q)
      S_QWR:   if (accept && idx_q == Q_LAST) begin pc_load_d = 1'b1; pc_val_d = LD_GAPQ; end
      S_KWR:   if (accept && idx_q == K_LAST) begin pc_load_d = 1'b1; pc_val_d = LD_GAPK; end
      S_GAP_K: if (pc_tc) begin pc_load_d = 1'b1; pc_val_d = LD_LOAD; end else pc_dec_d = 1'b1;
      S_LOAD:  if (pc_tc) begin pc_load_d = 1'b1; pc_val_d = LD_GAPL; end else pc_dec_d = 1'b1;
      S_GAP_L: pc_dec_d = 1'b1;
      S_EXEC:  if (idx_q == Q_LAST) begin pc_load_d = 1'b1; pc_val_d = LD_GAPE; end
      S_GAP_E: pc_dec_d = 1'b1;
      default: ;
    endcase
  end

  // Main FSM with registered instruction, data, busy and done outputs.
  // inst defaults to zero every cycle; each state ORs in its fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      inst_q  <= '0;
      mem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      inst_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        // The done_q guard rejects a start raised while done is showing.
        S_IDLE: if (start && !done_q) begin
          state_q <= S_QWR;
          busy_q  <= 1'b1;
          idx_q   <= '0;
        end
        S_QWR: if (accept) begin
          inst_q[QWR]               <= 1'b1;
          inst_q[QKADD_HI:QKADD_LO] <= idx_q;
          mem_q                     <= in_data;
          if (idx_q == Q_LAST) begin
            idx_q   <= '0;
            state_q <= S_GAP_Q;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_GAP_Q: state_q <= S_KWR;
        S_KWR: if (accept) begin
          inst_q[KWR]               <= 1'b1;
          inst_q[QKADD_HI:QKADD_LO] <= idx_q;
          mem_q                     <= in_data;
          if (idx_q == K_LAST) begin
            idx_q   <= '0;
            state_q <= S_GAP_K;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_GAP_K: if (pc_tc) state_q <= S_LOAD;
        // First (count = col+1) and last (count = 0) load cycles carry no read.
        S_LOAD: begin
          inst_q[LOAD] <= 1'b1;
          if (!pc_tc && pc_cnt != LD_LOAD) begin
            inst_q[KRD]               <= 1'b1;
            inst_q[QKADD_HI:QKADD_LO] <= idx_q;
            idx_q                     <= idx_q + 1'b1;
          end
          if (pc_tc) begin
            idx_q   <= '0;
            state_q <= S_GAP_L;
          end
        end
        S_GAP_L: if (pc_tc) state_q <= S_EXEC;
        S_EXEC: begin
          inst_q[EXEC]              <= 1'b1;
          inst_q[QRD]               <= 1'b1;
          inst_q[QKADD_HI:QKADD_LO] <= idx_q;
          if (idx_q == Q_LAST) begin
            idx_q   <= '0;
            state_q <= S_GAP_E;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_GAP_E: if (pc_tc) state_q <= S_DRAIN;
        S_DRAIN: begin
          inst_q[OFIFO_RD]        <= 1'b1;
          inst_q[PWR]             <= 1'b1;
          inst_q[PADD_HI:PADD_LO] <= idx_q;
          if (idx_q == Q_LAST) begin
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst   = inst_q;
  assign mem_in = mem_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer. A schedule model builds the
// expected per-cycle trace from phase lengths; two instances cover the
// default and a reduced-col / full-16 configuration.
module tb_inst_sequencer;
  import fullchip_pkg::*;

  localparam int MAXC = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;

  logic        rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
  logic [63:0] mem_a, mem_b;
  logic [18:0] inst_a, inst_b;

  always #5 clk = ~clk;

  inst_sequencer #(.bw(8), .pr(8), .col(8), .total_cycle(8), .idle_gap(10)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .mem_in(mem_a), .inst(inst_a), .busy(busy_a), .done(done_a));

  inst_sequencer #(.bw(8), .pr(8), .col(4), .total_cycle(16), .idle_gap(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .mem_in(mem_b), .inst(inst_b), .busy(busy_b), .done(done_b));

  bit          sel_b = 1'b0;
  logic [18:0] o_inst;
  logic [63:0] o_mem;
  logic        o_busy, o_done, o_rdy;

  always_comb begin
    o_inst = sel_b ? inst_b : inst_a;
    o_mem  = sel_b ? mem_b  : mem_a;
    o_busy = sel_b ? busy_b : busy_a;
    o_done = sel_b ? done_b : done_a;
    o_rdy  = sel_b ? rdy_b  : rdy_a;
  end

  int total = 0;
  int bad   = 0;

  // Expected trace, indexed by "after edge k" (edge 0 samples start).
  logic [18:0] e_inst[MAXC];
  logic [63:0] e_mem[MAXC];
  bit          e_busy[MAXC], e_done[MAXC], e_rdy[MAXC];
  // Stimulus sampled at edge k.
  bit          dv[MAXC], bub[MAXC], st[MAXC], mset[MAXC];
  logic [63:0] dd[MAXC], mv[MAXC];
  // Observed trace.
  logic [18:0] ob_inst[MAXC];
  logic [63:0] ob_mem[MAXC];
  logic        ob_busy[MAXC], ob_done[MAXC], ob_rdy[MAXC];
  logic [63:0] qrow[16], krow[16];
  int          end_k;

  function automatic bit outside_valid(int vmode);
    return (vmode == 2) ? 1'b1 : (vmode == 1) ? 1'($urandom_range(1)) : 1'b0;
  endfunction

  // Schedule model: walks the phases in order, placing each instruction at
  // the edge it must appear after. bub[] marks host bubbles in QWR/KWR.
  task automatic build(input int C, input int T, input int G, input int vmode);
    int k, p;
    logic [63:0] cur;
    for (int i = 0; i < MAXC; i++) begin
      e_inst[i] = '0; e_busy[i] = 0; e_done[i] = 0; e_rdy[i] = 0;
      mset[i] = 0; mv[i] = '0; st[i] = 0;
      dv[i] = outside_valid(vmode);
      dd[i] = {$urandom, $urandom};
    end
    st[0] = 1; dd[0] = qrow[0];
    k = 1; p = 0;
    while (p < T && k < MAXC - 200) begin
      e_rdy[k-1] = 1; dd[k] = qrow[p];
      if (bub[k]) dv[k] = 0;
      else begin
        dv[k] = 1; e_inst[k] = 19'((1 << QWR) | (p << QKADD_LO));
        mset[k] = 1; mv[k] = qrow[p]; p++;
      end
      k++;
    end
    dd[k] = krow[0]; if (vmode != 0) dv[k] = 1; k++;   // GAP_Q: offered K row must wait
    p = 0;
    while (p < C && k < MAXC - 200) begin
      e_rdy[k-1] = 1; dd[k] = krow[p];
      if (bub[k]) dv[k] = 0;
      else begin
        dv[k] = 1; e_inst[k] = 19'((1 << KWR) | (p << QKADD_LO));
        mset[k] = 1; mv[k] = krow[p]; p++;
      end
      k++;
    end
    k += 3;
    for (int i = 0; i < C + 2; i++)
      e_inst[k+i] = 19'((1 << LOAD) | ((i >= 1 && i <= C) ? ((1 << KRD) | ((i - 1) << QKADD_LO)) : 0));
    k += C + 2 + G;
    for (int i = 0; i < T; i++) e_inst[k+i] = 19'((1 << EXEC) | (1 << QRD) | (i << QKADD_LO));
    k += T + G + 1;
    for (int i = 0; i < T; i++) e_inst[k+i] = 19'((1 << OFIFO_RD) | (1 << PWR) | (i << PADD_LO));
    k += T;
    end_k = k; e_done[k] = 1;
    for (int i = 0; i < k; i++) e_busy[i] = 1;
    cur = '0;
    for (int i = 0; i < MAXC; i++) begin
      if (mset[i]) cur = mv[i];
      e_mem[i] = cur;
    end
  endtask

  task automatic clear_bub();
    for (int i = 0; i < MAXC; i++) bub[i] = 0;
  endtask

  task automatic rand_rows();
    for (int i = 0; i < 16; i++) begin
      qrow[i] = {$urandom, $urandom}; krow[i] = {$urandom, $urandom};
    end
  endtask

  // Drive stimulus for edges 0..n-1 and capture outputs at the following negedge.
  task automatic drive(input int n);
    for (int k = 0; k < n; k++) begin
      start = st[k]; in_valid = dv[k]; in_data = dd[k];
      @(posedge clk);
      @(negedge clk);
      ob_inst[k] = o_inst; ob_mem[k] = o_mem; ob_busy[k] = o_busy;
      ob_done[k] = o_done; ob_rdy[k] = o_rdy;
    end
    start = 0; in_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; in_valid = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; start = 1; in_data = {$urandom, $urandom};
    @(negedge clk); @(negedge clk);
    total++;
    if ({o_inst, o_mem, o_busy, o_done, o_rdy} !== {19'h0, 64'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_state got inst=%h mem=%h busy=%b done=%b rdy=%b expected all zero",
               o_inst, o_mem, o_busy, o_done, o_rdy);
    end
    reset = 0; start = 0; in_valid = 0;
  endtask

  task automatic test_basic();
    sel_b = 0; do_reset(); clear_bub();
    for (int i = 0; i < 16; i++) begin qrow[i] = 64'(i + 1); krow[i] = 64'(8'h11 + i); end
    build(8, 8, 10, 2);
    drive(end_k + 3);
    for (int k = 0; k < end_k + 3; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL basic k=%0d got inst=%h mem=%h b/d/r=%b%b%b expected inst=%h mem=%h b/d/r=%b%b%b",
                 k, ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k],
                 e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]);
      end
    end
  endtask

  task automatic test_bubbles();
    sel_b = 0; do_reset(); clear_bub(); rand_rows();
    bub[4] = 1; bub[5] = 1;   // two idle cycles after the third Q word
    build(8, 8, 10, 0);
    drive(end_k + 3);
    for (int k = 0; k < end_k + 3; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL bubbles k=%0d got inst=%h mem=%h b/d/r=%b%b%b expected inst=%h mem=%h b/d/r=%b%b%b",
                 k, ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k],
                 e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    sel_b = 0; do_reset(); clear_bub(); rand_rows();
    build(8, 8, 10, 1);
    st[end_k - 8 - 11 - 8 + 3] = 1;   // inside EXEC
    st[end_k] = 1;                    // sampled in the DONE state
    st[end_k + 1] = 1;                // sampled while done is showing
    drive(end_k + 4);
    for (int k = 0; k < end_k + 4; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL start_busy k=%0d got inst=%h mem=%h b/d/r=%b%b%b expected inst=%h mem=%h b/d/r=%b%b%b",
                 k, ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k],
                 e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    sel_b = 0; do_reset(); clear_bub(); rand_rows();
    build(8, 8, 10, 0);
    drive(26);   // after edge 25 the run is mid-LOAD
    for (int k = 0; k < 26; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL pre_reset k=%0d got inst=%h busy=%b expected inst=%h busy=%b",
                 k, ob_inst[k], ob_busy[k], e_inst[k], e_busy[k]);
      end
    end
    #2 reset = 1;
    #1;
    total++;
    if ({o_inst, o_mem, o_busy, o_done, o_rdy} !== {19'h0, 64'h0, 3'b000}) begin
      bad++;
      $display("FAIL async_reset got inst=%h mem=%h busy=%b done=%b rdy=%b expected all zero",
               o_inst, o_mem, o_busy, o_done, o_rdy);
    end
    @(negedge clk); reset = 0;
    rand_rows(); build(8, 8, 10, 0);
    drive(end_k + 2);
    for (int k = 0; k < end_k + 2; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL rerun k=%0d got inst=%h mem=%h b/d/r=%b%b%b expected inst=%h mem=%h b/d/r=%b%b%b",
                 k, ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k],
                 e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]);
      end
    end
  endtask

  task automatic test_small_col();
    sel_b = 1; do_reset(); clear_bub(); rand_rows();
    build(4, 16, 2, 0);
    drive(end_k + 3);
    for (int k = 0; k < end_k + 3; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL small_col k=%0d got inst=%h mem=%h b/d/r=%b%b%b expected inst=%h mem=%h b/d/r=%b%b%b",
                 k, ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k],
                 e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]);
      end
    end
    sel_b = 0;
  endtask

  task automatic test_valid_outside();
    sel_b = 0; do_reset(); clear_bub(); rand_rows();
    in_valid = 1; in_data = qrow[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({o_inst, o_mem, o_busy, o_rdy} !== {19'h0, 64'h0, 2'b00}) begin
        bad++;
        $display("FAIL idle_valid cyc=%0d got inst=%h mem=%h busy=%b rdy=%b expected zeros",
                 i, o_inst, o_mem, o_busy, o_rdy);
      end
    end
    build(8, 8, 10, 2);
    drive(end_k + 2);
    for (int k = 0; k < end_k + 2; k++) begin
      total++;
      if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
          {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
        bad++;
        $display("FAIL valid_outside k=%0d got inst=%h mem=%h rdy=%b expected inst=%h mem=%h rdy=%b",
                 k, ob_inst[k], ob_mem[k], ob_rdy[k], e_inst[k], e_mem[k], e_rdy[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      sel_b = it[0]; do_reset(); rand_rows(); clear_bub();
      for (int i = 1; i < 120; i++) bub[i] = ($urandom_range(99) < 25);
      if (sel_b) build(4, 16, 2, 1); else build(8, 8, 10, 1);
      drive(end_k + 2);
      for (int k = 0; k < end_k + 2; k++) begin
        total++;
        if ({ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k]} !==
            {e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]}) begin
          bad++;
          $display("FAIL random it=%0d k=%0d got inst=%h mem=%h b/d/r=%b%b%b expected inst=%h mem=%h b/d/r=%b%b%b",
                   it, k, ob_inst[k], ob_mem[k], ob_busy[k], ob_done[k], ob_rdy[k],
                   e_inst[k], e_mem[k], e_busy[k], e_done[k], e_rdy[k]);
        end
      end
    end
    sel_b = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bubbles();
    test_start_while_busy();
    test_async_reset();
    test_small_col();
    test_valid_outside();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
